clock_set_controller: RTL and testbench

- Sequencing controller for the HH:MM:SS time-keeping datapath.
- Generates the 1-second run tick and runs the RUN / SET_HR / SET_MIN mode FSM from two raw push-buttons (MODE, INC).
- Issues single-cycle minute/hour increment pulses with auto-repeat, and returns to RUN on inactivity timeout.
- Sits between the board buttons / system clock and the time counter chain: drives its enable, Set_clock, MIN and HR controls.

---
 rtl/clock_ctrl_pkg.sv | 15 +
 rtl/button_debouncer.sv | 48 ++++
 rtl/clock_set_controller.sv | 168 ++++++++++++++++
 tb/tb_clock_set_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings and counter sizing for the clock-set controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_t;

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, level debounce and rising-edge press pulse for one raw button.
module button_debouncer import clock_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Accept the new level; the press pulse lines up with the cycle after the rise.
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// Mode FSM, 1 s prescaler, increment auto-repeat and inactivity timeout for the HH:MM:SS counter chain.
//   state   | meaning
//   RUN     | time runs, sec_tick issued each base tick
//   SET_HR  | INC steps hours, display blinks
//   SET_MIN | INC steps minutes, leaving via MODE zeroes seconds
module clock_set_controller import clock_ctrl_pkg::*; #(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter int TIMEOUT_TICKS   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_tick,
    output logic       set_clock,
    output logic       min_pulse,
    output logic       hr_pulse,
    output logic       sec_clear,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam int TW = cnt_width(TIMEOUT_TICKS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_TICKS - 1);

    logic mode_press;
    logic mode_level_unused;
    logic inc_press;
    logic inc_level;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst     (reset),
        .btn_i   (btn_mode),
        .level_o (mode_level_unused),
        .press_o (mode_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk     (clk),
        .rst     (reset),
        .btn_i   (btn_inc),
        .level_o (inc_level),
        .press_o (inc_press)
    );

    logic [PW-1:0] presc_q;
    logic          base_tick;

    assign base_tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= base_tick ? '0 : presc_q + 1'b1;
        end
    end

    mode_t         state_q;
    logic          set_clock_q;
    logic          sec_tick_q;
    logic          min_q;
    logic          hr_q;
    logic          clr_q;
    logic          blink_q;
    logic          rep_arm_q;
    logic [RW-1:0] rep_q;
    logic [TW-1:0] tmo_q;

    logic in_set;
    logic inc_accept;
    logic timeout_hit;

    assign in_set      = (state_q != RUN);
    assign inc_accept  = inc_press && in_set;
    assign timeout_hit = in_set && base_tick && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            set_clock_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            min_q       <= 1'b0;
            hr_q        <= 1'b0;
            clr_q       <= 1'b0;
            blink_q     <= 1'b0;
            rep_arm_q   <= 1'b0;
            rep_q       <= '0;
            tmo_q       <= '0;
        end else begin
            sec_tick_q <= base_tick && (state_q == RUN);
            min_q      <= 1'b0;
            hr_q       <= 1'b0;
            clr_q      <= 1'b0;
            // Priority: MODE press, then INC press, then timeout, then repeat/idle housekeeping.
            if (mode_press) begin
                rep_arm_q <= 1'b0;
                rep_q     <= '0;
                tmo_q     <= '0;
                case (state_q)
                    RUN: begin
                        state_q     <= SET_HR;
                        set_clock_q <= 1'b1;
                        blink_q     <= 1'b0;
                    end
                    SET_HR: begin
                        state_q     <= SET_MIN;
                        set_clock_q <= 1'b1;
                        blink_q     <= blink_q ^ base_tick;
                    end
                    default: begin
                        state_q     <= RUN;
                        set_clock_q <= 1'b0;
                        blink_q     <= 1'b0;
                        clr_q       <= 1'b1;
                    end
                endcase
            end else if (inc_accept) begin
                tmo_q     <= '0;
                rep_arm_q <= 1'b1;
                rep_q     <= '0;
                blink_q   <= blink_q ^ base_tick;
                hr_q      <= (state_q == SET_HR);
                min_q     <= (state_q != SET_HR);
            end else if (timeout_hit) begin
                state_q     <= RUN;
                set_clock_q <= 1'b0;
                blink_q     <= 1'b0;
                rep_arm_q   <= 1'b0;
                rep_q       <= '0;
                tmo_q       <= '0;
            end else if (in_set) begin
                blink_q <= blink_q ^ base_tick;
                if (base_tick) begin
                    tmo_q <= tmo_q + 1'b1;
                end
                if (rep_arm_q && inc_level) begin
                    if (rep_q == REP_LAST) begin
                        rep_q <= '0;
                        hr_q  <= (state_q == SET_HR);
                        min_q <= (state_q != SET_HR);
                    end else begin
                        rep_q <= rep_q + 1'b1;
                    end
                end else begin
                    rep_arm_q <= 1'b0;
                    rep_q     <= '0;
                end
            end
        end
    end

    assign mode      = state_q;
    assign set_clock = set_clock_q;
    assign sec_tick  = sec_tick_q;
    assign min_pulse = min_q;
    assign hr_pulse  = hr_q;
    assign sec_clear = clr_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short timing parameters.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_tick;
    logic       set_clock;
    logic       min_pulse;
    logic       hr_pulse;
    logic       sec_clear;
    logic [1:0] mode;
    logic       blink;

    int checks = 0;
    int errors = 0;
    int n_cyc = 0;
    int tick_cnt = 0;
    int min_cnt = 0;
    int hr_cnt = 0;
    int clr_cnt = 0;
    int blink_toggles = 0;
    logic blink_prev = 1'b0;

    int t0;
    int b0;
    int m0;
    int h0;
    int c0;

    always #5 clk = ~clk;

    clock_set_controller #(
        .TICK_DIV        (10),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (20),
        .TIMEOUT_TICKS   (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_tick  (sec_tick),
        .set_clock (set_clock),
        .min_pulse (min_pulse),
        .hr_pulse  (hr_pulse),
        .sec_clear (sec_clear),
        .mode      (mode),
        .blink     (blink)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, n_cyc);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, n_cyc);
        end
    endtask

    task automatic chk_mode(input string tag, input logic [31:0] exp);
        chk_val(tag, {30'd0, mode}, exp);
    endtask

    task automatic step();
        @(negedge clk);
        n_cyc++;
        if (sec_tick === 1'b1) tick_cnt++;
        if (min_pulse === 1'b1) min_cnt++;
        if (hr_pulse === 1'b1) hr_cnt++;
        if (sec_clear === 1'b1) clr_cnt++;
        if (blink !== blink_prev) blink_toggles++;
        blink_prev = blink;
        chk_bit("pulse_exclusive", $onehot0({min_pulse, hr_pulse, sec_clear}), 1'b1);
    endtask

    task automatic run_to(input int target);
        while (n_cyc < target) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk_mode(tag, 32'd0);
        chk_bit(tag, sec_tick, 1'b0);
        chk_bit(tag, set_clock, 1'b0);
        chk_bit(tag, min_pulse, 1'b0);
        chk_bit(tag, hr_pulse, 1'b0);
        chk_bit(tag, sec_clear, 1'b0);
        chk_bit(tag, blink, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;
        n_cyc = 0;

        // Idle in RUN: base tick every 10 cycles.
        t0 = tick_cnt; m0 = min_cnt; h0 = hr_cnt; c0 = clr_cnt;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk_bit("idle_sec_tick", sec_tick, (i % 10) == 0);
        end
        chk_val("idle_tick_count", tick_cnt - t0, 32'd10);
        chk_val("idle_no_pulses", (min_cnt - m0) + (hr_cnt - h0) + (clr_cnt - c0), 32'd0);
        chk_mode("idle_mode", 32'd0);
        chk_bit("idle_blink", blink, 1'b0);

        // Clean MODE press at 100: SET_HR seven cycles later.
        btn_mode = 1'b1;
        while (n_cyc < 106) begin
            step();
            chk_mode("press_latency_early", 32'd0);
        end
        step();
        chk_mode("press_latency", 32'd1);
        chk_bit("set_clock_on", set_clock, 1'b1);
        t0 = tick_cnt; b0 = blink_toggles; c0 = clr_cnt;
        run_to(110);
        btn_mode = 1'b0;
        run_to(147);
        chk_val("set_no_sec_tick", tick_cnt - t0, 32'd0);
        chk_val("set_blink_toggles", blink_toggles - b0, 32'd4);
        chk_mode("hr_before_timeout", 32'd1);
        run_to(149);
        chk_mode("hr_last_cycle", 32'd1);
        step();
        chk_mode("timeout_to_run", 32'd0);
        chk_bit("timeout_set_clock", set_clock, 1'b0);
        chk_bit("timeout_blink", blink, 1'b0);
        chk_val("timeout_no_clear", clr_cnt - c0, 32'd0);

        // Three 3-cycle glitches, then a stable hold: one mode step only.
        for (int g = 0; g < 3; g++) begin
            btn_mode = 1'b1;
            for (int k = 0; k < 3; k++) begin
                step();
                chk_mode("glitch_ignored", 32'd0);
            end
            btn_mode = 1'b0;
            for (int k = 0; k < 2; k++) begin
                step();
                chk_mode("glitch_ignored", 32'd0);
            end
        end
        btn_mode = 1'b1;
        while (n_cyc < 171) begin
            step();
            chk_mode("bounce_wait", 32'd0);
        end
        step();
        chk_mode("bounce_one_step", 32'd1);
        run_to(175);
        btn_mode = 1'b0;
        run_to(180);
        chk_mode("bounce_stays_hr", 32'd1);

        // SET_MIN, hold INC: pulses at 197/217/237, timeout at 240 ends the repeat.
        btn_mode = 1'b1;
        run_to(187);
        chk_mode("enter_set_min", 32'd2);
        run_to(188);
        btn_mode = 1'b0;
        run_to(190);
        btn_inc = 1'b1;
        m0 = min_cnt;
        while (n_cyc < 260) begin
            step();
            chk_bit("rep_min_pulse", min_pulse, n_cyc == 197 || n_cyc == 217 || n_cyc == 237);
            chk_bit("rep_no_hr", hr_pulse, 1'b0);
            chk_bit("rep_no_clear", sec_clear, 1'b0);
            chk_mode("rep_mode", (n_cyc < 240) ? 32'd2 : 32'd0);
        end
        chk_val("rep_min_count", min_cnt - m0, 32'd3);
        btn_inc = 1'b0;

        // MODE path SET_MIN -> RUN gives a single sec_clear.
        run_to(270);
        btn_mode = 1'b1;
        run_to(277);
        chk_mode("cycle_hr", 32'd1);
        run_to(280);
        btn_mode = 1'b0;
        run_to(290);
        btn_mode = 1'b1;
        run_to(297);
        chk_mode("cycle_min", 32'd2);
        run_to(300);
        btn_mode = 1'b0;
        run_to(305);
        btn_mode = 1'b1;
        c0 = clr_cnt;
        while (n_cyc < 320) begin
            step();
            chk_bit("sec_clear_pulse", sec_clear, n_cyc == 312);
            chk_mode("cycle_run", (n_cyc < 312) ? 32'd2 : 32'd0);
            if (n_cyc == 315) btn_mode = 1'b0;
        end
        chk_val("sec_clear_count", clr_cnt - c0, 32'd1);

        // MODE and INC together in SET_HR: MODE wins, no increment, no repeat.
        btn_mode = 1'b1;
        run_to(327);
        chk_mode("simul_enter_hr", 32'd1);
        run_to(330);
        btn_mode = 1'b0;
        run_to(340);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        while (n_cyc < 385) begin
            step();
            chk_bit("simul_no_hr", hr_pulse, 1'b0);
            chk_bit("simul_no_min", min_pulse, 1'b0);
            chk_mode("simul_mode", (n_cyc < 347) ? 32'd1 : 32'd2);
            if (n_cyc == 350) btn_mode = 1'b0;
        end
        btn_inc = 1'b0;

        // Hour repeat in SET_HR, then async reset in the middle of it.
        run_to(400);
        chk_mode("back_in_run", 32'd0);
        btn_mode = 1'b1;
        run_to(407);
        chk_mode("hr_for_repeat", 32'd1);
        run_to(410);
        btn_mode = 1'b0;
        btn_inc = 1'b1;
        h0 = hr_cnt;
        while (n_cyc < 445) begin
            step();
            chk_bit("hr_repeat_pulse", hr_pulse, n_cyc == 417 || n_cyc == 437);
            chk_bit("hr_repeat_no_min", min_pulse, 1'b0);
        end
        chk_val("hr_repeat_count", hr_cnt - h0, 32'd2);
        chk_bit("pre_reset_set_clock", set_clock, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_held");
        reset = 1'b0;
        n_cyc = 0;

        // After reset: INC in RUN is ignored, ticks restart from zero.
        m0 = min_cnt; h0 = hr_cnt; t0 = tick_cnt;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) btn_inc = 1'b1;
            if (i == 25) btn_inc = 1'b0;
            step();
            chk_bit("post_reset_tick", sec_tick, (i % 10) == 0);
            chk_mode("post_reset_mode", 32'd0);
        end
        chk_val("run_inc_ignored", (min_cnt - m0) + (hr_cnt - h0), 32'd0);
        chk_val("post_reset_ticks", tick_cnt - t0, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
